// File: rtl/hs_pkg.sv
//------------------------------------------------------------------------------
// hs_pkg : shared defaults, width helper and FSM state type for the
//          multi-channel staging buffer.  Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package hs_pkg;

  localparam int W_DEF     = 32;
  localparam int DEPTH_DEF = 16;
  localparam int NCH_DEF   = 4;
  localparam int BURST_DEF = 8;

  // Occupancy width: must be able to represent DEPTH itself.
  function automatic int cw(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ib_fifo.sv
//------------------------------------------------------------------------------
// ib_fifo : single-clock first-word-fall-through FIFO, one per channel.
//           Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ib_fifo
  import hs_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CW    = cw(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] cnt,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= din;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop_ok)  rptr <= rptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/multi_input_buffer.sv
//------------------------------------------------------------------------------
// multi_input_buffer : per-channel FWFT staging with round-robin burst drain
//                      into a shared downstream FIFO.  Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module multi_input_buffer
  import hs_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int NCH   = NCH_DEF,
  parameter int BURST = BURST_DEF,
  parameter int CW    = cw(DEPTH),
  parameter int CHW   = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH*W-1:0]  din,
  input  logic [NCH-1:0]    i_enq,
  input  logic              flush,
  input  logic              full,
  output logic [W-1:0]      dout,
  output logic [CHW-1:0]    dout_ch,
  output logic              enq,
  output logic              last,
  output logic [NCH-1:0]    i_full,
  output logic [NCH*CW-1:0] ecnt,
  output logic [NCH-1:0]    ovf,
  output logic              busy
);

  state_t         state, state_n;
  logic [CHW-1:0] gch, gch_n;
  logic [CHW-1:0] rr, rr_n;
  logic [CW-1:0]  rem, rem_n;
  logic           flush_pend, flush_pend_n;

  logic [W-1:0]   fifo_dout [NCH];
  logic [CW-1:0]  fifo_cnt  [NCH];
  logic [NCH-1:0] fifo_push;
  logic [NCH-1:0] fifo_pop;
  logic [NCH-1:0] fifo_empty;
  logic [NCH-1:0] eligible;
  logic           all_empty;

  logic           found;
  logic [CHW-1:0] gnt;
  logic [CHW-1:0] cand;
  int             idx;

  genvar c;
  generate
    for (c = 0; c < NCH; c++) begin : g_ch
      ib_fifo #(
        .W     (W),
        .DEPTH (DEPTH),
        .CW    (CW)
      ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push[c]),
        .pop   (fifo_pop[c]),
        .din   (din[c*W +: W]),
        .dout  (fifo_dout[c]),
        .cnt   (fifo_cnt[c]),
        .full  (i_full[c]),
        .empty (fifo_empty[c])
      );
      assign fifo_push[c]       = i_enq[c] && !i_full[c];
      assign ecnt[c*CW +: CW]   = fifo_cnt[c];
      assign eligible[c]        = (fifo_cnt[c] >= CW'(BURST)) ||
                                  (flush_pend && !fifo_empty[c]);
    end
  endgenerate

  assign all_empty = &fifo_empty;

  // Search starts one past the last granted channel, wrapping once round.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    idx   = 0;
    cand  = '0;
    for (int k = 1; k <= NCH; k++) begin
      idx = int'(rr) + k;
      if (idx >= NCH) idx = idx - NCH;
      cand = CHW'(idx);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        gnt   = cand;
      end
    end
  end

  always_comb begin
    state_n  = state;
    gch_n    = gch;
    rem_n    = rem;
    rr_n     = rr;
    enq      = 1'b0;
    last     = 1'b0;
    fifo_pop = '0;
    case (state)
      IDLE: begin
        if (found) begin
          state_n = DRAIN;
          gch_n   = gnt;
          if (flush_pend && (fifo_cnt[gnt] < CW'(BURST))) rem_n = fifo_cnt[gnt];
          else                                            rem_n = CW'(BURST);
        end
      end
      DRAIN: begin
        enq = !full;
        if (enq) begin
          fifo_pop[gch] = 1'b1;
          rem_n         = rem - CW'(1);
          if (rem == CW'(1)) begin
            last    = 1'b1;
            state_n = IDLE;
            rr_n    = gch;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    flush_pend_n = flush_pend;
    if (!flush_pend)                      flush_pend_n = flush;
    else if (state == IDLE && all_empty)  flush_pend_n = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gch        <= '0;
      rr         <= CHW'(NCH - 1);
      rem        <= '0;
      flush_pend <= 1'b0;
      ovf        <= '0;
    end else begin
      state      <= state_n;
      gch        <= gch_n;
      rr         <= rr_n;
      rem        <= rem_n;
      flush_pend <= flush_pend_n;
      ovf        <= ovf | (i_enq & i_full);
    end
  end

  assign dout    = enq ? fifo_dout[gch] : '0;
  assign dout_ch = gch;
  assign busy    = (state == DRAIN) || flush_pend;

endmodule

`default_nettype wire

// File: tb/tb_multi_input_buffer.sv
//------------------------------------------------------------------------------
// tb_multi_input_buffer : directed stimulus, queue-based reference model and
//                         per-cycle comparison.  Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_multi_input_buffer;

  localparam int W     = 32;
  localparam int DEPTH = 16;
  localparam int NCH   = 4;
  localparam int BURST = 8;
  localparam int CW    = 5;
  localparam int CHW   = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH*W-1:0]  din;
  logic [NCH-1:0]    i_enq;
  logic              flush;
  logic              full;
  logic [W-1:0]      dout;
  logic [CHW-1:0]    dout_ch;
  logic              enq;
  logic              last;
  logic [NCH-1:0]    i_full;
  logic [NCH*CW-1:0] ecnt;
  logic [NCH-1:0]    ovf;
  logic              busy;

  multi_input_buffer #(
    .W(W), .DEPTH(DEPTH), .NCH(NCH), .BURST(BURST)
  ) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .i_enq(i_enq), .flush(flush),
    .full(full), .dout(dout), .dout_ch(dout_ch), .enq(enq), .last(last),
    .i_full(i_full), .ecnt(ecnt), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: word queues per channel plus the current burst.
  logic [W-1:0]   q [NCH][$];
  bit             m_active;
  int             m_ch, m_rem, m_rr;
  bit             m_fp;
  bit [NCH-1:0]   m_ovf;

  typedef struct { int ch; logic [W-1:0] data; bit last; } ent_t;
  ent_t obs[$];

  task automatic mreset();
    for (int c = 0; c < NCH; c++) q[c].delete();
    m_active = 0; m_ch = 0; m_rem = 0; m_rr = NCH - 1; m_fp = 0; m_ovf = '0;
  endtask

  task automatic mstep();
    int  sz [NCH];
    bit  was_active, popping, all0, found;
    int  ch;
    all0 = 1;
    for (int c = 0; c < NCH; c++) begin
      sz[c] = q[c].size();
      if (sz[c] != 0) all0 = 0;
    end
    was_active = m_active;
    popping    = m_active && !full;
    for (int c = 0; c < NCH; c++)
      if (i_enq[c]) begin
        if (sz[c] == DEPTH) m_ovf[c] = 1;
        else                q[c].push_back(din[c*W +: W]);
      end
    if (popping) begin
      void'(q[m_ch].pop_front());
      m_rem--;
      if (m_rem == 0) begin m_active = 0; m_rr = m_ch; end
    end else if (!was_active) begin
      found = 0;
      for (int k = 1; k <= NCH; k++) begin
        ch = (m_rr + k) % NCH;
        if (!found && (sz[ch] >= BURST || (m_fp && sz[ch] != 0))) begin
          found = 1; m_active = 1; m_ch = ch;
          m_rem = (m_fp && sz[ch] < BURST) ? sz[ch] : BURST;
        end
      end
    end
    if (!m_fp)                   m_fp = flush;
    else if (!was_active && all0) m_fp = 0;
  endtask

  always @(negedge rst_n) mreset();
  always @(posedge clk) begin
    if (!rst_n) mreset();
    else        mstep();
  end

  // Inputs change at posedge+2, so the falling edge sees settled outputs.
  always @(negedge clk) begin
    bit              m_enq;
    logic [NCH*CW-1:0] e_ecnt;
    logic [NCH-1:0]  e_full;
    m_enq = m_active && !full;
    for (int c = 0; c < NCH; c++) begin
      e_ecnt[c*CW +: CW] = CW'(q[c].size());
      e_full[c]          = (q[c].size() == DEPTH);
    end
    check("enq", enq, m_enq);
    check("dout", dout, m_enq ? q[m_ch][0] : '0);
    check("last", last, m_enq && m_rem == 1);
    check("busy", busy, m_active || m_fp);
    check("ecnt", ecnt, e_ecnt);
    check("i_full", i_full, e_full);
    check("ovf", ovf, m_ovf);
    if (m_enq) check("dout_ch", dout_ch, m_ch);
    if (enq) obs.push_back('{int'(dout_ch), dout, last});
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  logic [W-1:0] t2 [8] = '{32'd4532, 32'd32651, 32'd65432, 32'd1234,
                           32'd999, 32'd70000, 32'd5, 32'd123456};
  logic [CW-1:0] frozen;

  initial begin
    rst_n = 1'b0; din = '0; i_enq = '0; flush = 1'b0; full = 1'b0;
    #1;
    check("rst_enq", enq, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ecnt", ecnt, '0);
    check("rst_dout", dout, '0);
    check("rst_dout_ch", dout_ch, '0);
    check("rst_i_full", i_full, '0);
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Single burst on ch0
    obs.delete();
    for (int i = 0; i < 8; i++) begin
      din[0 +: W] = t2[i]; i_enq = 4'b0001; tick(1);
    end
    i_enq = '0;
    tick(15);
    check("t2_count", obs.size(), 8);
    for (int i = 0; i < 8 && i < obs.size(); i++) begin
      check("t2_ch", obs[i].ch, 0);
      check("t2_data", obs[i].data, t2[i]);
      check("t2_last", obs[i].last, i == 7);
    end
    check("t2_ecnt0", ecnt[0 +: CW], 0);

    // Round-robin between ch1 and ch3, twice
    for (int r = 0; r < 2; r++) begin
      obs.delete();
      for (int i = 0; i < 8; i++) begin
        din[1*W +: W] = 32'h100 + i; din[3*W +: W] = 32'h300 + i;
        i_enq = 4'b1010; tick(1);
      end
      i_enq = '0;
      tick(25);
      check("t3_count", obs.size(), 16);
      for (int i = 0; i < 16 && i < obs.size(); i++) begin
        check("t3_ch", obs[i].ch, i < 8 ? 1 : 3);
        check("t3_data", obs[i].data, (i < 8 ? 32'h100 : 32'h300) + (i % 8));
      end
    end

    // Backpressure mid-burst on ch2
    obs.delete();
    for (int i = 0; i < 8; i++) begin
      din[2*W +: W] = 32'hA00 + i; i_enq = 4'b0100; tick(1);
    end
    i_enq = '0;
    for (int n = 0; n < 40 && obs.size() < 3; n++) tick(1);
    check("t4_reached3", obs.size() >= 3, 1'b1);
    full = 1'b1;
    frozen = ecnt[2*CW +: CW];
    check("t4_ecnt_at_stall", frozen, 5);
    tick(5);
    check("t4_enq_stalled", enq, 1'b0);
    check("t4_ecnt_frozen", ecnt[2*CW +: CW], frozen);
    full = 1'b0;
    tick(15);
    check("t4_count", obs.size(), 8);
    for (int i = 0; i < 8 && i < obs.size(); i++)
      check("t4_data", obs[i].data, 32'hA00 + i);

    // Flush of a 3-word residue on ch2
    obs.delete();
    for (int i = 0; i < 3; i++) begin
      din[2*W +: W] = 32'hC00 + i; i_enq = 4'b0100; tick(1);
    end
    i_enq = '0;
    tick(5);
    check("t5_no_burst", obs.size(), 0);
    flush = 1'b1; tick(1); flush = 1'b0;
    tick(10);
    check("t5_count", obs.size(), 3);
    for (int i = 0; i < 3 && i < obs.size(); i++) begin
      check("t5_ch", obs[i].ch, 2);
      check("t5_data", obs[i].data, 32'hC00 + i);
      check("t5_last", obs[i].last, i == 2);
    end
    check("t5_busy", busy, 1'b0);

    // Overflow on ch0 while downstream is full
    obs.delete();
    full = 1'b1;
    for (int i = 0; i < 17; i++) begin
      din[0 +: W] = 32'hD00 + i; i_enq = 4'b0001; tick(1);
    end
    i_enq = '0;
    tick(1);
    check("t6_ecnt0", ecnt[0 +: CW], 16);
    check("t6_i_full0", i_full[0], 1'b1);
    check("t6_ovf0", ovf[0], 1'b1);
    full = 1'b0;
    tick(30);
    check("t6_count", obs.size(), 16);
    for (int i = 0; i < obs.size(); i++)
      check("t6_data", obs[i].data, 32'hD00 + i);

    // Asynchronous reset in the middle of a burst
    obs.delete();
    for (int i = 0; i < 8; i++) begin
      din[1*W +: W] = 32'hE00 + i; i_enq = 4'b0010; tick(1);
    end
    i_enq = '0;
    for (int n = 0; n < 20 && enq !== 1'b1; n++) tick(1);
    check("t1_burst_started", enq, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t1_enq", enq, 1'b0);
    check("t1_ecnt", ecnt, '0);
    check("t1_busy", busy, 1'b0);
    check("t1_ovf", ovf, '0);
    tick(2);
    rst_n = 1'b1;
    tick(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
